// File: rtl/spi_peripheral_if.sv
// SPI peripheral bus bundle: serial pins plus user-side TX/RX handshake and status.
interface spi_peripheral_if;
  localparam int unsigned DATA_W = 8;

  logic              SPI_CLK;
  logic              SPI_EN;
  logic              SPI_MOSI;
  logic              SPI_MISO;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  SPI_CLK, SPI_EN, SPI_MOSI, tx_data, tx_valid,
    output SPI_MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );

  modport master (
    output SPI_CLK, SPI_EN, SPI_MOSI, tx_data, tx_valid,
    input  SPI_MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI responder (CPOL=1, active-low enable, MSB first, 8-bit) in the clk domain.
module spi_peripheral #(
  parameter logic [7:0] DEFAULT_TX = 8'hFF
) (
  input logic           clk,
  input logic           rst,
  spi_peripheral_if.slave bus
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  // synchronizers and history flops
  logic clk_s1, clk_s2, clk_h;
  logic en_s1, en_s2, en_h;
  logic mosi_s1, mosi_s2, mosi_h;
  // registered edge flags
  logic clk_rise_q, clk_fall_q, en_rise_q, sel_q;

  logic [BYTE_W-1:0] hold, hold_d;
  logic              hold_full, hold_full_d;
  logic [BYTE_W-1:0] shift, shift_d;
  logic              shift_user, shift_user_d;
  logic [BYTE_W-1:0] rxsr, rxsr_d;
  logic [CNT_W-1:0]  fcnt, fcnt_d;
  logic              done, done_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_underrun_q, tx_underrun_d;
  logic              frame_err_q, frame_err_d;
  logic              tx_ready_q;
  logic              reload;

  // pin synchronization and edge detection (3-cycle pin-to-action latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      {clk_s1, clk_s2, clk_h}    <= 3'b111;
      {en_s1, en_s2, en_h}       <= 3'b111;
      {mosi_s1, mosi_s2, mosi_h} <= 3'b000;
      clk_rise_q <= 1'b0;
      clk_fall_q <= 1'b0;
      en_rise_q  <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      clk_s1  <= bus.SPI_CLK;
      clk_s2  <= clk_s1;
      clk_h   <= clk_s2;
      en_s1   <= bus.SPI_EN;
      en_s2   <= en_s1;
      en_h    <= en_s2;
      mosi_s1 <= bus.SPI_MOSI;
      mosi_s2 <= mosi_s1;
      mosi_h  <= mosi_s2;
      clk_rise_q <= clk_s2 & ~clk_h;
      clk_fall_q <= ~clk_s2 & clk_h;
      en_rise_q  <= en_s2 & ~en_h;
      sel_q      <= ~en_s2;
    end
  end

  // next-state for holding register, shifters, frame counter and strobes
  always_comb begin
    hold_d        = hold;
    hold_full_d   = hold_full;
    shift_d       = shift;
    shift_user_d  = shift_user;
    rxsr_d        = rxsr;
    fcnt_d        = fcnt;
    done_d        = done;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    reload        = 1'b0;

    if (en_rise_q) begin
      // deselect: abort an unfinished byte and flush any pending reload
      if (fcnt != '0 || done) begin
        frame_err_d = 1'b1;
        fcnt_d      = '0;
        rxsr_d      = '0;
        done_d      = 1'b0;
        reload      = 1'b1;
      end
    end else if (sel_q) begin
      if (clk_fall_q) begin
        rxsr_d = {rxsr[BYTE_W-2:0], mosi_h};
        fcnt_d = fcnt + CNT_W'(1);
        if (fcnt == CNT_W'(7)) begin
          rx_data_d  = {rxsr[BYTE_W-2:0], mosi_h};
          rx_valid_d = 1'b1;
          done_d     = 1'b1;
        end
      end
      if (clk_rise_q) begin
        if (done) begin
          reload = 1'b1;
          done_d = 1'b0;
        end else begin
          shift_d = {shift[BYTE_W-2:0], 1'b0};
        end
      end
    end else if (hold_full && !shift_user) begin
      // idle: stage a user byte so bit 7 is on MISO before selection
      shift_d      = hold;
      shift_user_d = 1'b1;
      hold_full_d  = 1'b0;
    end

    if (reload) begin
      if (hold_full) begin
        shift_d      = hold;
        shift_user_d = 1'b1;
        hold_full_d  = 1'b0;
      end else begin
        shift_d       = DEFAULT_TX;
        shift_user_d  = 1'b0;
        tx_underrun_d = 1'b1;
      end
    end

    // user write; cannot coincide with a hold-consuming load since tx_ready is then low
    if (bus.tx_valid && tx_ready_q) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end
  end

  // datapath state register
  always_ff @(posedge clk) begin
    if (rst) begin
      hold          <= '0;
      hold_full     <= 1'b0;
      shift         <= DEFAULT_TX;
      shift_user    <= 1'b0;
      rxsr          <= '0;
      fcnt          <= '0;
      done          <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      tx_ready_q    <= 1'b1;
    end else begin
      hold          <= hold_d;
      hold_full     <= hold_full_d;
      shift         <= shift_d;
      shift_user    <= shift_user_d;
      rxsr          <= rxsr_d;
      fcnt          <= fcnt_d;
      done          <= done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      tx_ready_q    <= ~hold_full_d;
    end
  end

  assign bus.SPI_MISO    = shift[BYTE_W-1];
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = sel_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral acting as the SPI master on its pins.
module tb_spi_peripheral;
  localparam int DIV = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_peripheral_if bus();
  spi_peripheral #(.DEFAULT_TX(8'hFF)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int und_cnt = 0;
  int ferr_cnt = 0;
  int und_snap = 0;
  logic [7:0] rx_last = 8'h00;
  logic [7:0] rx_prev = 8'h00;

  // strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_prev = rx_last;
      rx_last = bus.rx_data;
      rx_cnt++;
    end
    if (bus.tx_underrun) und_cnt++;
    if (bus.frame_err) ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [7:0] d);
    int n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 100) begin
      tick(1);
      n++;
    end
    check("tx_ready_for_write", 32'(bus.tx_ready), 32'd1);
    tick(1);
    bus.tx_valid = 1'b0;
  endtask

  // one byte with SPI_CLK idle high and enable already low
  task automatic spi_byte(input logic [7:0] txb, output logic [7:0] rdb);
    logic [7:0] sh;
    sh = txb;
    bus.SPI_MOSI = sh[7];
    tick(DIV);
    for (int i = 7; i >= 0; i--) begin
      bus.SPI_CLK = 1'b0;
      rdb[i] = bus.SPI_MISO;
      tick(DIV);
      if (i == 0) und_snap = und_cnt;
      bus.SPI_CLK = 1'b1;
      sh = {sh[6:0], 1'b0};
      bus.SPI_MOSI = sh[7];
      tick(DIV);
    end
  endtask

  task automatic deselect();
    bus.SPI_EN = 1'b1;
    tick(DIV + 4);
  endtask

  logic [7:0] rd, rd2;
  int rx0, und0, ferr0;

  initial begin
    rst = 1'b1;
    bus.SPI_CLK = 1'b1;
    bus.SPI_EN = 1'b1;
    bus.SPI_MOSI = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_valid = 1'b0;
    tick(3);
    check("rst_miso", 32'(bus.SPI_MISO), 32'd1);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_rx_data", 32'(bus.rx_data), 32'h00);
    check("rst_strobes", {29'd0, bus.rx_valid, bus.tx_underrun, bus.frame_err}, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick(5);

    // preloaded byte
    tx_write(8'hA5);
    tick(3);
    check("pre_tx_ready", 32'(bus.tx_ready), 32'd1);
    rx0 = rx_cnt; und0 = und_cnt; ferr0 = ferr_cnt;
    bus.SPI_EN = 1'b0;
    spi_byte(8'h3C, rd);
    deselect();
    check("pre_master_rd", 32'(rd), 32'hA5);
    check("pre_rx_data", 32'(rx_last), 32'h3C);
    check("pre_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("pre_no_underrun_in_byte", 32'(und_snap - und0), 32'd0);
    check("pre_no_frame_err", 32'(ferr_cnt - ferr0), 32'd0);

    // underrun
    rx0 = rx_cnt; und0 = und_cnt;
    bus.SPI_EN = 1'b0;
    spi_byte(8'h81, rd);
    deselect();
    check("und_master_rd", 32'(rd), 32'hFF);
    check("und_rx_data", 32'(rx_last), 32'h81);
    check("und_pulse_count", 32'(und_cnt - und0), 32'd1);
    check("und_before_last_rise", 32'(und_snap - und0), 32'd0);

    // back-to-back bytes in one enable window
    tx_write(8'h11);
    tick(3);
    rx0 = rx_cnt; und0 = und_cnt;
    bus.SPI_EN = 1'b0;
    fork
      begin
        spi_byte(8'hF0, rd);
        spi_byte(8'h0F, rd2);
      end
      begin
        tick(2 * DIV + 3);
        tx_write(8'h22);
      end
    join
    deselect();
    check("b2b_master_rd1", 32'(rd), 32'h11);
    check("b2b_master_rd2", 32'(rd2), 32'h22);
    check("b2b_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("b2b_rx_first", 32'(rx_prev), 32'hF0);
    check("b2b_rx_second", 32'(rx_last), 32'h0F);
    check("b2b_no_underrun", 32'(und_snap - und0), 32'd0);

    // abort after 3 bits
    rx0 = rx_cnt; ferr0 = ferr_cnt;
    bus.SPI_EN = 1'b0;
    bus.SPI_MOSI = 1'b1;
    tick(DIV);
    for (int i = 0; i < 3; i++) begin
      bus.SPI_CLK = 1'b0;
      tick(DIV);
      bus.SPI_CLK = 1'b1;
      bus.SPI_MOSI = ~bus.SPI_MOSI;
      tick(DIV);
    end
    deselect();
    check("abort_frame_err", 32'(ferr_cnt - ferr0), 32'd1);
    check("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
    check("abort_fcnt", 32'(dut.fcnt), 32'd0);
    check("abort_miso_default", 32'(bus.SPI_MISO), 32'd1);
    rx0 = rx_cnt;
    bus.SPI_EN = 1'b0;
    spi_byte(8'hC3, rd);
    deselect();
    check("post_abort_rx", 32'(rx_last), 32'hC3);
    check("post_abort_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("post_abort_rd", 32'(rd), 32'hFF);

    // deselected noise
    rx0 = rx_cnt; und0 = und_cnt; ferr0 = ferr_cnt;
    for (int i = 0; i < 6; i++) begin
      bus.SPI_CLK = ~bus.SPI_CLK;
      bus.SPI_MOSI = ~bus.SPI_MOSI;
      tick(DIV);
      check("noise_miso", 32'(bus.SPI_MISO), 32'd1);
    end
    tick(DIV);
    check("noise_strobes", 32'((rx_cnt - rx0) + (und_cnt - und0) + (ferr_cnt - ferr0)), 32'd0);
    check("noise_busy", 32'(bus.busy), 32'd0);

    // reset mid-frame
    tx_write(8'h77);
    tick(3);
    bus.SPI_EN = 1'b0;
    bus.SPI_MOSI = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      bus.SPI_CLK = 1'b0;
      tick(DIV);
      bus.SPI_CLK = 1'b1;
      tick(DIV);
    end
    check("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick(1);
    check("mrst_miso", 32'(bus.SPI_MISO), 32'd1);
    check("mrst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check("mrst_rx_data", 32'(bus.rx_data), 32'h00);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_fcnt", 32'(dut.fcnt), 32'd0);
    rst = 1'b0;
    deselect();
    rx0 = rx_cnt;
    bus.SPI_EN = 1'b0;
    spi_byte(8'h5A, rd);
    deselect();
    check("mrst_master_rd", 32'(rd), 32'hFF);
    check("mrst_rx_data_after", 32'(rx_last), 32'h5A);
    check("mrst_rx_count", 32'(rx_cnt - rx0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
